// File: rtl/fifo_arb_pkg.sv
// Shared constants and helpers for the FIFO write arbiter.
// State encoding is kept as plain 1-bit constants so older netlists stay compatible.
package fifo_arb_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;

  // Ceiling log2, evaluated at elaboration for port and counter widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating priority picker: first set request at or after ptr, wrapping modulo NUM_REQ.
// Purely combinational, no backpressure; found is low when no request is set.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]        req,
  input  logic [clog2(NUM_REQ)-1:0] ptr,
  output logic                      found,
  output logic [clog2(NUM_REQ)-1:0] idx
);

  localparam int IW = clog2(NUM_REQ);

  int pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin owner of the FIFO write port; one idle cycle to arbitrate, then up to MAX_BURST beats.
// Write and ready are gated by fifo_full_i in the same cycle; a stalled burst waits with no timeout.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 3,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        reset_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic                        fifo_full_i,
  output logic                        fifo_wr_en_o,
  output logic [DATA_W-1:0]           fifo_data_o,
  output logic [NUM_REQ-1:0]          grant_o,
  output logic [clog2(NUM_REQ)-1:0]   grant_id_o
);

  localparam int IW = clog2(NUM_REQ);
  localparam int BW = (clog2(MAX_BURST) > 1) ? clog2(MAX_BURST) : 1;
  localparam logic [IW-1:0] IW_ONE = IW'(1);
  localparam logic [BW-1:0] BW_ONE = BW'(1);

  logic          state;
  logic [IW-1:0] owner;
  logic [IW-1:0] rr_ptr;
  logic [BW-1:0] beat_cnt;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          in_burst;
  logic          owner_vld;
  logic          beat;
  logic          last_beat;
  logic [IW-1:0] next_ptr;

  rr_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_picker (
    .req  (req_valid_i),
    .ptr  (rr_ptr),
    .found(pick_found),
    .idx  (pick_idx)
  );

  assign in_burst  = (state == ST_BURST);
  assign owner_vld = req_valid_i[owner];
  assign beat      = in_burst & owner_vld & ~fifo_full_i;
  assign last_beat = (beat_cnt == BW'(MAX_BURST - 1));
  assign next_ptr  = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW_ONE;

  // Dropping valid ends the burst and still passes the turn on.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state    <= ST_IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else if (!in_burst) begin
      if (pick_found) begin
        state    <= ST_BURST;
        owner    <= pick_idx;
        beat_cnt <= '0;
      end
    end else if (!owner_vld || (beat && last_beat)) begin
      state  <= ST_IDLE;
      rr_ptr <= next_ptr;
    end else if (beat) begin
      beat_cnt <= beat_cnt + BW_ONE;
    end
  end

  // All outputs decode from registered state, so async reset clears them at once.
  always_comb begin
    req_ready_o  = '0;
    fifo_wr_en_o = 1'b0;
    fifo_data_o  = '0;
    grant_o      = '0;
    grant_id_o   = '0;
    if (in_burst) begin
      req_ready_o[owner] = ~fifo_full_i;
      fifo_wr_en_o       = owner_vld & ~fifo_full_i;
      fifo_data_o        = req_data_i[owner*DATA_W +: DATA_W];
      grant_o[owner]     = 1'b1;
      grant_id_o         = owner;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter (NUM_REQ=4, DATA_W=3, MAX_BURST=4).
// Inputs change on the falling edge; outputs are sampled a few ns later, before the rising edge.
module tb_fifo_write_arbiter;

  logic        clk;
  logic        reset_i;
  logic [3:0]  req_valid_i;
  logic [11:0] req_data_i;
  logic [3:0]  req_ready_o;
  logic        fifo_full_i;
  logic        fifo_wr_en_o;
  logic [2:0]  fifo_data_o;
  logic [3:0]  grant_o;
  logic [1:0]  grant_id_o;

  fifo_write_arbiter #(
    .NUM_REQ  (4),
    .DATA_W   (3),
    .MAX_BURST(4)
  ) dut (
    .clk         (clk),
    .reset_i     (reset_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .fifo_full_i (fifo_full_i),
    .fifo_wr_en_o(fifo_wr_en_o),
    .fifo_data_o (fifo_data_o),
    .grant_o     (grant_o),
    .grant_id_o  (grant_id_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  vld;
    logic [11:0] dat;
    logic        full;
    logic [3:0]  rdy;
    logic        wr;
    logic [2:0]  wdat;
    logic [3:0]  gnt;
    logic [1:0]  id;
  } vec_t;

  typedef struct packed {
    logic [1:0] id;
    logic [2:0] dat;
  } wr_t;

  vec_t tbl [9];
  wr_t  sb [$];
  int   checks   = 0;
  int   failures = 0;
  logic wr_seen;
  bit   model_en = 1'b0;
  int   fcount   = 0;

  int st_gnt  [11] = '{0, 2, 2, 2, 2, 2, 2, 2, 0, 2, 0};
  int st_full [11] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
  int st_dat  [11] = '{1, 1, 2, 3, 3, 3, 3, 4, 4, 0, 0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [2:0] d);
    sb.push_back('{id, d});
  endtask

  task automatic sample();
    wr_t e;
    wr_seen = fifo_wr_en_o;
    if (fifo_full_i) chk("full_gate", 32'({fifo_wr_en_o, req_ready_o}), 32'd0);
    if (fifo_wr_en_o) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_unexpected actual id=%0d data=%0d required=no write at %0t",
                 grant_id_o, fifo_data_o, $time);
      end else begin
        e = sb.pop_front();
        chk("wr_id", 32'(grant_id_o), 32'(e.id));
        chk("wr_dat", 32'(fifo_data_o), 32'(e.dat));
      end
    end
  endtask

  // One cycle: sample before the rising edge, return on the next falling edge.
  task automatic tick();
    #2;
    sample();
    @(negedge clk);
    if (model_en) begin
      if (wr_seen) fcount++;
      fifo_full_i = (fcount >= 8);
    end
  endtask

  initial begin
    reset_i     = 1'b0;
    req_valid_i = '0;
    req_data_i  = '0;
    fifo_full_i = 1'b0;

    tbl[0] = '{4'b0100, 12'h140, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b0000, 2'd0};
    tbl[1] = '{4'b0100, 12'h140, 1'b0, 4'b0100, 1'b1, 3'd5, 4'b0100, 2'd2};
    tbl[2] = '{4'b0100, 12'h080, 1'b0, 4'b0100, 1'b1, 3'd2, 4'b0100, 2'd2};
    tbl[3] = '{4'b0000, 12'h000, 1'b0, 4'b0100, 1'b0, 3'd0, 4'b0100, 2'd2};
    tbl[4] = '{4'b0000, 12'h000, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b0000, 2'd0};
    tbl[5] = '{4'b1100, 12'hE40, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b0000, 2'd0};
    tbl[6] = '{4'b1100, 12'hE40, 1'b0, 4'b1000, 1'b1, 3'd7, 4'b1000, 2'd3};
    tbl[7] = '{4'b0000, 12'h000, 1'b0, 4'b1000, 1'b0, 3'd0, 4'b1000, 2'd3};
    tbl[8] = '{4'b0000, 12'h000, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b0000, 2'd0};

    // Reset held with random inputs
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      req_valid_i = 4'($urandom);
      req_data_i  = 12'($urandom);
      fifo_full_i = 1'($urandom);
      #2;
      chk("reset_out", 32'({req_ready_o, fifo_wr_en_o, fifo_data_o, grant_o, grant_id_o}), 32'd0);
      @(negedge clk);
    end
    req_valid_i = '0;
    req_data_i  = '0;
    fifo_full_i = 1'b0;
    reset_i     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("idle_out", 32'({fifo_wr_en_o, grant_o}), 32'd0);
      tick();
    end

    // Single producer and pointer follow-up, table driven
    for (int i = 0; i < 9; i++) begin
      req_valid_i = tbl[i].vld;
      req_data_i  = tbl[i].dat;
      fifo_full_i = tbl[i].full;
      if (tbl[i].wr) push(tbl[i].id, tbl[i].wdat);
      #1;
      chk($sformatf("vec%0d_rdy", i), 32'(req_ready_o), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_wr", i), 32'(fifo_wr_en_o), 32'(tbl[i].wr));
      chk($sformatf("vec%0d_dat", i), 32'(fifo_data_o), 32'(tbl[i].wdat));
      chk($sformatf("vec%0d_gnt", i), 32'(grant_o), 32'(tbl[i].gnt));
      chk($sformatf("vec%0d_id", i), 32'(grant_id_o), 32'(tbl[i].id));
      tick();
    end
    chk("single_sb_empty", 32'(sb.size()), 32'd0);

    // Rotation: all valid, FIFO never full
    req_valid_i = 4'hF;
    req_data_i  = 12'h8D1;
    for (int b = 0; b < 5; b++)
      for (int n = 0; n < 4; n++) push(2'(b % 4), 3'(b % 4 + 1));
    for (int t = 0; t < 25; t++) begin
      #1;
      chk($sformatf("rot_gnt%0d", t), 32'(grant_o),
          (t % 5 == 0) ? 32'd0 : 32'(1 << ((t / 5) % 4)));
      tick();
    end
    req_valid_i = '0;
    tick();
    chk("rot_sb_empty", 32'(sb.size()), 32'd0);

    // Full stall during producer 1's burst
    for (int n = 1; n <= 4; n++) push(2'd1, 3'(n));
    for (int t = 0; t < 11; t++) begin
      req_valid_i = (t < 9) ? 4'b0010 : 4'b0000;
      req_data_i  = 12'(st_dat[t] << 3);
      fifo_full_i = st_full[t][0];
      #1;
      chk($sformatf("stall_gnt%0d", t), 32'(grant_o), 32'(st_gnt[t]));
      tick();
    end
    chk("stall_sb_empty", 32'(sb.size()), 32'd0);

    // Depth-8 FIFO, no reads
    model_en    = 1'b1;
    fcount      = 0;
    fifo_full_i = 1'b0;
    req_valid_i = 4'b1100;
    req_data_i  = 12'hCC0;
    for (int n = 0; n < 4; n++) push(2'd2, 3'd3);
    for (int n = 0; n < 4; n++) push(2'd3, 3'd6);
    for (int t = 0; t < 16; t++) tick();
    chk("depth_count", 32'(fcount), 32'd8);
    chk("depth_sb_empty", 32'(sb.size()), 32'd0);
    req_valid_i = '0;
    tick();
    model_en    = 1'b0;
    fifo_full_i = 1'b0;
    tick();

    // Abandon after one beat, then next grant from the advanced pointer
    req_data_i = 12'hE05;
    push(2'd0, 3'd5);
    push(2'd3, 3'd7);
    req_valid_i = 4'b0001;
    #1; chk("ab_idle0", 32'(grant_o), 32'd0);
    tick();
    #1; chk("ab_gnt0", 32'(grant_o), 32'b0001);
    tick();
    req_valid_i = 4'b0000;
    #1; chk("ab_drop", 32'({grant_o, fifo_wr_en_o}), 32'b00010);
    tick();
    req_valid_i = 4'b1001;
    #1; chk("ab_idle1", 32'(grant_o), 32'd0);
    tick();
    #1; chk("ab_next_gnt", 32'({grant_o, grant_id_o}), 32'({4'b1000, 2'd3}));
    tick();
    req_valid_i = 4'b0000;
    tick();
    tick();
    chk("ab_sb_empty", 32'(sb.size()), 32'd0);

    // Async reset during beat 3 of producer 2
    req_valid_i = 4'b0100;
    req_data_i  = 12'h080;
    for (int n = 0; n < 3; n++) push(2'd2, 3'd2);
    tick();
    tick();
    tick();
    #2;
    sample();
    #1;
    reset_i = 1'b0;
    #1;
    chk("async_rst", 32'({req_ready_o, fifo_wr_en_o, fifo_data_o, grant_o, grant_id_o}), 32'd0);
    @(negedge clk);
    req_valid_i = 4'b0110;
    req_data_i  = 12'h0A8;
    #1;
    chk("rst_held", 32'({req_ready_o, fifo_wr_en_o, grant_o}), 32'd0);
    @(negedge clk);
    reset_i = 1'b1;
    push(2'd1, 3'd5);
    #1; chk("rst_idle", 32'(grant_o), 32'd0);
    tick();
    #1; chk("rst_first_gnt", 32'(grant_o), 32'b0010);
    tick();
    req_valid_i = '0;
    tick();
    tick();
    chk("rst_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write arbiter that shares the single write port of `synchronous_fifo` among `NUM_REQ` producers. It grants one producer at a time for a burst of up to `MAX_BURST` beats and drives the FIFO's `wr_en_i`/`data_i` from the granted producer. It never issues a write while the FIFO reports full. It sits between the producer blocks and the FIFO write side; the FIFO read side is untouched.

## Interface
- `NUM_REQ`, default 4: number of producers; at least 2.
- `DATA_W`, default 3: data width; equals the FIFO data width.
- `MAX_BURST`, default 4: maximum beats per grant; at least 1.
- `clk`  in  1: single clock, rising edge.
- `reset_i`  in  1: asynchronous, active-low reset.
- `req_valid_i`  in  NUM_REQ: per-producer valid; bit k belongs to producer k.
- `req_data_i`  in  NUM_REQ*DATA_W: producer k data in bits [k*DATA_W +: DATA_W].
- `req_ready_o`  out  NUM_REQ: per-producer ready; a beat for producer k occurs when valid[k] and ready[k] are both high.
- `fifo_full_i`  in  1: the FIFO's `full_o`.
- `fifo_wr_en_o`  out  1: drives the FIFO's `wr_en_i`.
- `fifo_data_o`  out  DATA_W: drives the FIFO's `data_i`.
- `grant_o`  out  NUM_REQ: one-hot current owner; all zero when idle.
- `grant_id_o`  out  clog2(NUM_REQ): binary index of the owner; 0 when idle.

## Operation
- **Registered state:**
  - `state` ∈ {IDLE, BURST}.
  - `owner`.
  - `rr_ptr`, width clog2(NUM_REQ).
  - `beat_cnt`, width max(1, clog2(MAX_BURST)).
- **IDLE:**
  - Scan `req_valid_i` starting at index `rr_ptr`, ascending, with wrap modulo NUM_REQ. The first set bit wins.
  - If a winner exists: next state BURST, `owner` = winner, `beat_cnt` = 0.
  - If no bit is set: stay in IDLE.
  - No ready and no write are issued in IDLE.
- **BURST, combinational outputs:**
  - `req_ready_o[owner]` = !fifo_full_i; all other ready bits are 0.
  - `fifo_wr_en_o` = req_valid_i[owner] & !fifo_full_i.
  - `fifo_data_o` = owner's data slice.
  - Outside BURST, `fifo_wr_en_o` = 0 and `fifo_data_o` = 0.
- **BURST, beat without end of burst:** a beat with `beat_cnt` < MAX_BURST-1 increments `beat_cnt`.
- **BURST, end of burst:**
  - A beat with `beat_cnt` == MAX_BURST-1 is the last beat. The next state is IDLE and `rr_ptr` = owner+1 mod NUM_REQ.
  - If `req_valid_i[owner]` is low, the burst is abandoned. No beat occurs, the next state is IDLE and `rr_ptr` = owner+1 mod NUM_REQ.
- **BURST, full stall:** if `fifo_full_i` is high and owner valid is high, stay in BURST with `beat_cnt` held. There is no timeout.
- **Producer rule:** data must stay stable while valid is high and ready is low. Dropping valid before a beat is legal and means abandon.
- **Round-robin pointer:** `rr_ptr` advances only on leaving BURST. A producer that drops valid mid-burst still loses its turn.

## Timing
- **Reset values**, applied immediately on `reset_i` low, independent of `clk`:
  - state IDLE; `rr_ptr`, `owner` and `beat_cnt` 0.
  - All outputs 0.
- **Reset mid-burst:** the burst is terminated with no write. After release, arbitration restarts from producer 0.
- **Arbitration latency:** 1 cycle. If valid is sampled high in IDLE at edge N, grant and ready are high in cycle N+1.
- **Throughput:** one bubble cycle (IDLE) between bursts. Peak rate is MAX_BURST writes per MAX_BURST+1 cycles.
- **Full handling:** `fifo_full_i` gates write and ready in the same cycle. The FIFO's count updates on the write edge, so a write in the cycle where count = depth-1 is legal.
- **Same-cycle read and write:** the FIFO read side may read in the same cycle as a write. Only `fifo_full_i` matters to this block.
- **Owner outputs:** `grant_o` and `grant_id_o` are registered from `owner`/`state` and are stable for the whole burst.

## Structure
- **Package `fifo_arb_pkg`:**
  - State encoding localparams ST_IDLE = 1'b0, ST_BURST = 1'b1.
  - Function `clog2` used for the `rr_ptr`, `grant_id_o` and `beat_cnt` widths.
- **Sub-module `rr_picker`:** purely combinational, parameter NUM_REQ.
  - Inputs: `req` and `ptr`.
  - Outputs: `found` and `idx`.
  - Performs a rotate-and-priority-encode.
- **Top level:** the FSM, counters and output muxing.

## Test plan
- **Reset:** hold `reset_i` low with random inputs → every output is 0. Release, all valid low for 5 cycles → state stays IDLE and there is no `fifo_wr_en_o`.
- **Single producer:** producer 2 valid with data 3'h5 then 3'h2, FIFO empty.
  - `grant_o` = 4'b0100 one cycle after valid.
  - Two consecutive writes of 5 then 2; `grant_id_o` = 2.
  - IDLE after valid drops; `rr_ptr` = 3.
- **Rotation:** all four producers valid continuously, FIFO drained every cycle.
  - Grants go 0, 1, 2, 3, 0, each for 4 writes, with exactly one idle cycle between bursts.
- **Full stall:** full asserted after 2 beats of producer 1, held for 3 cycles.
  - During the stall: `fifo_wr_en_o` = 0 and `req_ready_o` = 0, with `beat_cnt` holding at 2.
  - After full deasserts: 2 more writes, then the burst ends.
  - With FIFO depth 8 fed without reads, no write occurs while count = 8.
- **Abandon:** producer 0 drops valid after 1 beat while producers 0 and 3 are both valid again.
  - The burst ends and the next grant goes to producer 3, the first valid producer from `rr_ptr` = 1.
- **Async reset mid-burst:** pull `reset_i` low between clock edges during beat 3 → all outputs go to 0 before the next edge. After release, the first grant goes to the lowest-index valid producer.
